// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory-side types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_owner_t;

  localparam int STARVE_CNT_W = 8;

  function automatic logic ram_settled(input ramstate_t st);
    return (st == ACCESS) || (st == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  word_t             iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  word_t             dstore;
  logic              dwait;
  word_t             dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  word_t             ramstore;
  word_t             ramload;
  ramstate_t         ramstate;
  logic              starved;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, starved
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, starved
  );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// rtl/mem_arbiter_starve_counter.sv - saturating count of consecutive denied fetch cycles
module starve_counter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == STARVE_CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between instruction fetch and data access
// Registered owner, data priority, fetch forced through once the starvation counter saturates.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 32
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  arb_owner_t        owner;
  arb_owner_t        owner_nxt;
  logic              i_req;
  logic              d_req;
  logic              owner_req;
  logic              hold;
  logic              starve_sat;
  logic              starve_inc;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] addr_mux;
  word_t             store_mux;

  assign i_req = bus.iREN;
  assign d_req = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner <= IDLE;
    end else begin
      owner <= owner_nxt;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    case (owner)
      GRANT_I: owner_req = i_req;
      GRANT_D: owner_req = d_req;
      default: owner_req = 1'b0;
    endcase
  end

  // A grant persists only while its request is up and the RAM has not finished or faulted.
  assign hold = owner_req && !ram_settled(bus.ramstate);

  always_comb begin
    owner_nxt = IDLE;
    if (hold) begin
      owner_nxt = owner;
    end else if (starve_sat && i_req) begin
      owner_nxt = GRANT_I;
    end else if (d_req) begin
      owner_nxt = GRANT_D;
    end else if (i_req) begin
      owner_nxt = GRANT_I;
    end
  end

  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    addr_mux  = '0;
    store_mux = '0;
    case (owner)
      GRANT_I: begin
        ram_ren  = i_req;
        addr_mux = bus.iaddr;
      end
      GRANT_D: begin
        ram_wen   = bus.dWEN;
        ram_ren   = bus.dREN & ~bus.dWEN;
        addr_mux  = bus.daddr;
        store_mux = bus.dstore;
      end
      default: ;
    endcase
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = addr_mux;
  assign bus.ramstore = store_mux;

  assign bus.iwait = ~((owner == GRANT_I) && i_req && (bus.ramstate == ACCESS));
  assign bus.dwait = ~((owner == GRANT_D) && d_req && (bus.ramstate == ACCESS));
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  assign starve_inc = i_req && (owner_nxt != GRANT_I);

  starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk(CLK),
    .rst(RST),
    .inc(starve_inc),
    .clr(~starve_inc),
    .sat(starve_sat)
  );

  assign bus.starved = starve_sat;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   m_owner = 0;  // 0 none, 1 fetch side, 2 data side
  int   m_cnt = 0;

  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .STARVE_MAX(SMAX),
    .ADDR_W(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model just before the edge, then advance the model.
  task automatic cycle();
    bit gi, gd, dreq, settled, hold;
    int nxt, ncnt;
    #2;
    gi      = (m_owner == 1);
    gd      = (m_owner == 2);
    dreq    = bus.dREN | bus.dWEN;
    settled = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
    chk1("ramREN", bus.ramREN, gi ? bus.iREN : (gd ? (bus.dREN & ~bus.dWEN) : 1'b0));
    chk1("ramWEN", bus.ramWEN, gd ? bus.dWEN : 1'b0);
    chk32("ramaddr", bus.ramaddr, gi ? bus.iaddr : (gd ? bus.daddr : 32'h0));
    if (!gi) chk32("ramstore", bus.ramstore, gd ? bus.dstore : 32'h0);
    chk1("iwait", bus.iwait, !(gi && bus.iREN && bus.ramstate == ACCESS));
    chk1("dwait", bus.dwait, !(gd && dreq && bus.ramstate == ACCESS));
    chk32("iload", bus.iload, bus.ramload);
    chk32("dload", bus.dload, bus.ramload);
    chk1("starved", bus.starved, m_cnt == SMAX);
    hold = ((gi && bus.iREN) || (gd && dreq)) && !settled;
    if (hold)                          nxt = m_owner;
    else if (m_cnt == SMAX && bus.iREN) nxt = 1;
    else if (dreq)                      nxt = 2;
    else if (bus.iREN)                  nxt = 1;
    else                                nxt = 0;
    ncnt = (bus.iREN && nxt != 1) ? ((m_cnt < SMAX) ? m_cnt + 1 : SMAX) : 0;
    @(posedge CLK);
    m_owner = RST ? 0 : nxt;
    m_cnt   = RST ? 0 : ncnt;
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.iaddr = 32'h0; bus.daddr = 32'h0; bus.dstore = 32'h0;
    bus.ramstate = FREE; bus.ramload = 32'h0;
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    #1;
    chk1("rst_ramREN", bus.ramREN, 1'b0);
    chk1("rst_ramWEN", bus.ramWEN, 1'b0);
    chk32("rst_ramaddr", bus.ramaddr, 32'h0);
    chk32("rst_ramstore", bus.ramstore, 32'h0);
    chk1("rst_iwait", bus.iwait, 1'b1);
    chk1("rst_dwait", bus.dwait, 1'b1);
    chk1("rst_starved", bus.starved, 1'b0);
    @(negedge CLK);
    cycle();
    RST = 1'b0;
    cycle();

    // single fetch: BUSY, BUSY, ACCESS
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramload = 32'h8C220004; bus.ramstate = FREE;
    cycle();
    bus.ramstate = BUSY;
    #1 chk32("fetch_addr_c1", bus.ramaddr, 32'h100);
    chk1("fetch_wait_c1", bus.iwait, 1'b1);
    cycle();
    cycle();
    bus.ramstate = ACCESS;
    #1 chk1("fetch_wait_c3", bus.iwait, 1'b0);
    chk32("fetch_iload", bus.iload, 32'h8C220004);
    cycle();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    cycle();
    cycle();

    // contention: data first, then fetch with no idle gap
    bus.iREN = 1'b1; bus.iaddr = 32'h104; bus.dREN = 1'b1; bus.daddr = 32'h200;
    cycle();
    bus.ramstate = ACCESS;
    #1 chk32("cont_daddr", bus.ramaddr, 32'h200);
    chk1("cont_dwait", bus.dwait, 1'b0);
    chk1("cont_iwait", bus.iwait, 1'b1);
    cycle();
    bus.dREN = 1'b0; bus.ramstate = BUSY;
    cycle();
    #1 chk32("cont_iaddr", bus.ramaddr, 32'h104);
    chk1("cont_iren", bus.ramREN, 1'b1);
    bus.ramstate = ACCESS;
    cycle();
    idle_inputs();
    cycle();

    // write wins over read, then asynchronous reset mid-write
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'hDEADBEEF;
    cycle();
    bus.ramstate = BUSY;
    #1 chk1("wr_ramWEN", bus.ramWEN, 1'b1);
    chk1("wr_ramREN", bus.ramREN, 1'b0);
    chk32("wr_ramstore", bus.ramstore, 32'hDEADBEEF);
    cycle();
    #1 RST = 1'b1;
    #1 chk1("arst_ramWEN", bus.ramWEN, 1'b0);
    chk1("arst_dwait", bus.dwait, 1'b1);
    chk1("arst_iwait", bus.iwait, 1'b1);
    m_owner = 0; m_cnt = 0;
    cycle();
    RST = 1'b0;
    idle_inputs();
    bus.iREN = 1'b1; bus.iaddr = 32'h140;
    cycle();
    #1 chk1("post_rst_igrant", bus.ramREN, 1'b1);
    chk32("post_rst_iaddr", bus.ramaddr, 32'h140);
    bus.ramstate = ACCESS;
    cycle();
    idle_inputs();
    cycle();

    // starvation: writes complete every cycle while fetch waits
    bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.iREN = 1'b1; bus.iaddr = 32'h180;
    bus.ramstate = ACCESS;
    for (int k = 0; k < 4; k++) cycle();
    #1 chk1("starve_sat", bus.starved, 1'b1);
    chk1("starve_d_owner", bus.ramWEN, 1'b1);
    cycle();
    #1 chk1("starve_igrant", bus.ramREN, 1'b1);
    chk1("starve_cleared", bus.starved, 1'b0);
    chk1("starve_iwait", bus.iwait, 1'b0);
    cycle();
    idle_inputs();
    cycle();

    // withdrawal during BUSY, then an aborted fetch
    bus.dREN = 1'b1; bus.daddr = 32'h500;
    cycle();
    bus.ramstate = BUSY;
    cycle();
    bus.dREN = 1'b0;
    #1 chk1("wd_ramREN", bus.ramREN, 1'b0);
    chk1("wd_dwait", bus.dwait, 1'b1);
    cycle();
    bus.iREN = 1'b1; bus.iaddr = 32'h1C0; bus.ramstate = FREE;
    cycle();
    bus.ramstate = ERROR;
    #1 chk1("err_iwait", bus.iwait, 1'b1);
    cycle();
    bus.ramstate = ACCESS;
    #1 chk1("err_regrant", bus.ramREN, 1'b1);
    chk1("err_retry_done", bus.iwait, 1'b0);
    cycle();
    idle_inputs();
    cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(0, 3) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 4) == 0) bus.dWEN = ~bus.dWEN;
      if ($urandom_range(0, 2) == 0) bus.iaddr = $urandom;
      if ($urandom_range(0, 2) == 0) bus.daddr = $urandom;
      bus.dstore   = $urandom;
      bus.ramload  = $urandom;
      bus.ramstate = ramstate_t'($urandom_range(0, 3));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single unified RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side).
- Sits between the pipeline caches and the RAM model/bus; the hazard unit only sees the resulting ihit/dhit (derived from ~iwait/~dwait).
- Registered-grant FSM with data priority and a starvation guard for instruction fetch.

Parameters:
- STARVE_MAX, 8, number of consecutive arbitration cycles iREN may be denied before I is forced to win (1..255).
- ADDR_W, 32, address width (matches word_t).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  low in the cycle the I read completes; high otherwise.
- iload  out  32  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  32  write data.
- dwait  out  1  low in the cycle the D access completes; high otherwise.
- dload  out  32  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- starved  out  1  high while the starvation counter is saturated (debug/perf).

Behaviour:
- Reset: owner=IDLE; starve_cnt=0. Outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, starved=0. Reset is applied immediately on RST rise, with no clock edge needed.
- iload=dload=ramload at all times (combinational pass-through).
- States are IDLE, GRANT_I and GRANT_D. The owner register updates on the CLK rise only.
- Arbitration (next owner), evaluated in IDLE or in the completion/abort cycle of a grant:
  - If starve_cnt==STARVE_MAX and iREN: GRANT_I.
  - Else if dREN|dWEN: GRANT_D.
  - Else if iREN: GRANT_I.
  - Else: IDLE.
- GRANT_I drives: ramREN=iREN, ramWEN=0, ramaddr=iaddr.
- GRANT_D drives: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore. If dREN and dWEN are both high, the access is treated as a write.
- In IDLE, all RAM enables are 0 and ramaddr/ramstore hold 0.
- Completion: owner granted and ramstate==ACCESS with its request still high. The owner's wait goes low that same cycle, and the FSM re-arbitrates at the next edge. Back-to-back grants have no idle bubble.
- Withdrawal: if the owner drops its request before ACCESS, RAM enables drop combinationally in the same cycle and the FSM re-arbitrates at the next edge. No wait-low pulse is produced.
- ERROR: the access is aborted. Owner wait stays high, the FSM re-arbitrates at the next edge, and the requester retries naturally.
- The non-owner's wait is always 1.
- Latency: request seen in IDLE at cycle 0, grant at cycle 1. Earliest wait-low is cycle 1 if the RAM returns ACCESS immediately.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each edge where iREN=1 and the next owner != GRANT_I.
  - Clears on the edge that grants I, or when iREN=0.
  - starved = (starve_cnt==STARVE_MAX).
- No combinational path exists from ramstate to the owner register other than through the next-state logic. The RAM enables do not depend on ramstate.

Decomposition:
- Add arb_owner_t enum (IDLE, GRANT_I, GRANT_D) to cpu_types_pkg next to ramstate_t. word_t comes from the same package.
- One sub-module, starve_counter: a saturating counter with STARVE_MAX parameter, inc/clr inputs and a sat output.
- The FSM, priority logic and output muxing stay in mem_arbiter.

Test Plan:
- Reset: RST=1 mid-GRANT_D write -> ramWEN=0, dwait=1, iwait=1 asynchronously; after RST=0, the first edge with iREN=1 grants I.
- Single fetch: iREN=1, iaddr=0x100, RAM gives BUSY,BUSY,ACCESS -> ramREN=1 and ramaddr=0x100 from cycle 1, iwait=0 only in cycle 3, iload=ramload=0x8C220004.
- Contention: iREN and dREN rise together (daddr=0x200) -> D served first; I granted the edge after D's ACCESS with no IDLE cycle between.
- Write over read: dREN=dWEN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- Starvation: STARVE_MAX=4, dWEN held high with ACCESS every cycle, iREN=1 -> starved asserts and I is granted after 4 denied arbitrations; counter clears.
- Withdraw/error: dREN drops during BUSY -> ramREN=0 same cycle, no dwait pulse. ramstate=ERROR on an I fetch -> iwait stays 1 and I is re-granted.
